// File: rtl/pattern_serializer_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package pattern_serializer_pkg;

  localparam int DEF_WIDTH = 5;
  localparam logic [DEF_WIDTH-1:0] DEF_PATTERN = 5'b10101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Job request / serial output bundle between a job source and the serializer.
interface pattern_serializer_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic             use_default;
  logic [WIDTH-1:0] pat_in;
  logic [CNT_W-1:0] reps;
  logic             o;
  logic             o_valid;
  logic             busy;
  logic             done;

  modport master (output start, use_default, pat_in, reps,
                  input  o, o_valid, busy, done);
  modport slave  (input  start, use_default, pat_in, reps,
                  output o, o_valid, busy, done);
endinterface

// File: rtl/pattern_serializer_load_down_counter.sv
// Loadable down counter; tc flags a count of zero. Load wins over decrement,
// and the count saturates at zero.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;

  // Counter register: load, else decrement until zero.
  always_ff @(posedge clk) begin
    if (rst)                    count <= '0;
    else if (load)              count <= load_val;
    else if (dec && count != 0) count <= count - 1'b1;
  end

  assign tc = (count == '0);
endmodule

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB-first, optionally
// repeated with GAP zero cycles between repetitions.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(DEF_PATTERN),
  parameter int               CNT_W           = 4,
  parameter int               GAP             = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pattern_serializer_if.slave  bus
);
  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            NO_GAP   = (GAP == 0);

  state_t           state;
  logic [WIDTH-1:0] shreg, pat_lat, pat_sel;
  logic [CNT_W-1:0] rep_load_val;
  logic             accept, last_bit;
  logic             bit_load, bit_dec, bit_tc;
  logic             rep_load, rep_dec, rep_tc;
  logic             gap_load, gap_dec, gap_tc;

  // Counter control: counters hold "remaining after the current one".
  always_comb begin
    pat_sel      = bus.use_default ? DEFAULT_PATTERN : bus.pat_in;
    rep_load_val = (bus.reps == '0) ? '0 : bus.reps - 1'b1;
    accept       = (state == S_IDLE || state == S_DONE) && bus.start;
    last_bit     = (state == S_SEND) && bit_tc;
    bit_load     = accept || (last_bit && !rep_tc && NO_GAP) ||
                   (state == S_GAP && gap_tc);
    bit_dec      = (state == S_SEND) && !bit_tc;
    rep_load     = accept;
    rep_dec      = last_bit && !rep_tc;
    gap_load     = last_bit && !rep_tc && !NO_GAP;
    gap_dec      = (state == S_GAP) && !gap_tc;
  end

  load_down_counter #(.W(BW)) u_bit_cnt (
    .clk(clk), .rst(rst), .load(bit_load), .dec(bit_dec),
    .load_val(BIT_LOAD), .tc(bit_tc)
  );

  load_down_counter #(.W(CNT_W)) u_rep_cnt (
    .clk(clk), .rst(rst), .load(rep_load), .dec(rep_dec),
    .load_val(rep_load_val), .tc(rep_tc)
  );

  load_down_counter #(.W(GW)) u_gap_cnt (
    .clk(clk), .rst(rst), .load(gap_load), .dec(gap_dec),
    .load_val(GAP_LOAD), .tc(gap_tc)
  );

  // Main FSM; outputs are registered so o shows shreg's MSB in the same
  // cycle the state reports it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      pat_lat     <= '0;
      bus.o       <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state       <= S_IDLE;
          bus.o       <= 1'b0;
          bus.o_valid <= 1'b0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          if (accept) begin
            state       <= S_SEND;
            pat_lat     <= pat_sel;
            shreg       <= pat_sel;
            bus.o       <= pat_sel[WIDTH-1];
            bus.o_valid <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        S_SEND: begin
          if (!bit_tc) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            bus.o <= shreg[WIDTH-2];
          end else if (!rep_tc && NO_GAP) begin
            shreg <= pat_lat;
            bus.o <= pat_lat[WIDTH-1];
          end else if (!rep_tc) begin
            state       <= S_GAP;
            shreg       <= pat_lat;
            bus.o       <= 1'b0;
            bus.o_valid <= 1'b0;
          end else begin
            state       <= S_DONE;
            bus.o       <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_tc) begin
            state       <= S_SEND;
            bus.o       <= shreg[WIDTH-1];
            bus.o_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench: two serializers (GAP=0 and GAP=1); each job pushes the
// expected per-cycle {o, o_valid, busy, done} into a queue, the monitor pops
// one entry per cycle and expects all-zero outputs when the queue is empty.
module tb_pattern_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  pattern_serializer_if #(.WIDTH(5), .CNT_W(4)) if0 ();
  pattern_serializer_if #(.WIDTH(5), .CNT_W(4)) if1 ();

  pattern_serializer #(.WIDTH(5), .DEFAULT_PATTERN(5'b10101), .CNT_W(4), .GAP(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pattern_serializer #(.WIDTH(5), .DEFAULT_PATTERN(5'b10101), .CNT_W(4), .GAP(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {o,v,busy,done}=%b expected %b", tag, $time, got, exp);
    end
  endtask

  // Expected cycles of one job on a DUT with gap length g.
  task automatic push_job(input int which, input int g, input logic [4:0] pat, input int reps);
    int r;
    logic [3:0] e;
    r = (reps == 0) ? 1 : reps;
    for (int i = 0; i < r; i++) begin
      if (i > 0)
        for (int k = 0; k < g; k++) begin
          e = 4'b0010;
          if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
      for (int j = 4; j >= 0; j--) begin
        e = {pat[j], 3'b110};
        if (which == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    e = 4'b0001;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Pulse start for one cycle on the selected DUTs and record expectations.
  task automatic launch(input bit m0, input bit m1, input bit ud,
                        input logic [4:0] p, input logic [3:0] r);
    logic [4:0] eff;
    eff = ud ? 5'b10101 : p;
    @(negedge clk);
    if0.start = m0; if0.use_default = ud; if0.pat_in = p; if0.reps = r;
    if1.start = m1; if1.use_default = ud; if1.pat_in = p; if1.reps = r;
    if (m0) push_job(0, 0, eff, int'(r));
    if (m1) push_job(1, 1, eff, int'(r));
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    // Scramble job inputs mid-job; they must have no effect.
    if0.pat_in = ~p; if1.pat_in = ~p; if0.reps = 4'd7; if1.reps = 4'd7;
    if0.use_default = ~ud; if1.use_default = ~ud;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("job_timeout", {3'b0, n >= 400}, 4'b0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: sample just after each active edge.
  always @(posedge clk) begin
    logic [3:0] e0, e1;
    #1;
    e0 = (q0.size() != 0) ? q0.pop_front() : 4'b0;
    e1 = (q1.size() != 0) ? q1.pop_front() : 4'b0;
    chk("gap0_out", {if0.o, if0.o_valid, if0.busy, if0.done}, e0);
    chk("gap1_out", {if1.o, if1.o_valid, if1.busy, if1.done}, e1);
  end

  initial begin
    if0.start = 0; if0.use_default = 0; if0.pat_in = '0; if0.reps = '0;
    if1.start = 0; if1.use_default = 0; if1.pat_in = '0; if1.reps = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    launch(1, 1, 1, 5'b00000, 4'd1);   // default pattern once
    wait_idle();
    launch(1, 1, 0, 5'b11001, 4'd0);   // reps=0 behaves as 1
    wait_idle();
    launch(1, 1, 1, 5'b00000, 4'd2);   // back-to-back vs one-cycle gap
    wait_idle();
    for (int t = 0; t < 4; t++) begin
      launch(1, 1, 0, 5'($urandom), 4'($urandom_range(1, 3)));
      wait_idle();
    end
    launch(1, 1, 0, 5'b10011, 4'd15);  // maximum repetition count
    wait_idle();

    // start held high through a job on the GAP=1 DUT: ignored while busy,
    // accepted in the DONE cycle with the inputs present then.
    @(negedge clk);
    if1.start = 1; if1.use_default = 1; if1.reps = 4'd2; if1.pat_in = 5'b11001;
    push_job(1, 1, 5'b10101, 2);
    push_job(1, 1, 5'b11001, 1);
    repeat (2) @(negedge clk);
    if1.use_default = 0; if1.reps = 4'd1;
    repeat (11) @(negedge clk);
    if1.start = 0;
    wait_idle();

    // Reset held three cycles mid-SEND aborts both jobs with no done pulse.
    launch(1, 1, 1, 5'b00000, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    launch(1, 1, 0, 5'b01110, 4'd1);   // clean operation after reset
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
